ifu_axi_prefetch: RTL and testbench

// - Parametrised successor instruction-fetch unit: sequential AXI4-Lite read master plus an instruction prefetch FIFO.
// - Sits between the PC/redirect logic and the shared AXI read port.
// - Decoupled from IDU by valid/ready.
// - Adds over the single-shot fetch: autonomous sequential prefetch, redirect/flush with stale-response drop, lane select for DATA_W > INST_W, and access-fault reporting.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_inst_fifo.sv | 51 +++++
 rtl/ifu_axi_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_ifu_axi_prefetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the prefetching instruction-fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    ST_AR,
    ST_R,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } fetch_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_INST_W = 32;

  typedef struct packed {
    logic                    fault;
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous FIFO holding prefetched instruction entries; flush empties it in one cycle.
module ifu_inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && (count != '0);
  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ifu_axi_prefetch.sv
// Sequential AXI4-Lite instruction prefetcher: one outstanding read, FIFO-buffered
// results, redirect with stale-beat drop, lane select and fault halt.
module ifu_axi_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       INST_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_redirect_valid,
  input  logic [ADDR_W-1:0] io_redirect_pc,
  output logic              io_inst_valid,
  input  logic              io_inst_ready,
  output logic [INST_W-1:0] io_inst,
  output logic [ADDR_W-1:0] io_inst_pc,
  output logic              io_inst_fault,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  localparam int unsigned STEP   = INST_W / 8;
  localparam int unsigned LANES  = DATA_W / INST_W;
  localparam int unsigned OFF_LO = $clog2(STEP);
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);

  typedef struct packed {
    logic              fault;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] held_pc;
  logic [ADDR_W-1:0] cap_pc;
  logic [LANE_W-1:0] cap_lane;
  logic [LANE_W-1:0] lane_at_ar;
  logic [ADDR_W-1:0] araddr_i;
  logic              drop;
  logic              run;
  logic              arvalid_i;
  logic              rready_i;
  logic              ar_hs;
  logic              r_hs;
  logic              beat_fault;
  logic              push;
  logic              pop;
  logic              pop_ok;
  logic              inst_valid;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cnt_after_push;
  logic [CNT_W-1:0]  cnt_after_pop;
  logic [INST_W-1:0] lane_inst;
  entry_t            push_entry;
  entry_t            head;

  // While a dropped request is still waiting for arready, the old address stays on the bus.
  assign araddr_i   = drop ? held_pc : fetch_pc;
  assign lane_at_ar = (LANES > 1) ? araddr_i[OFF_LO +: LANE_W] : '0;

  assign ar_hs      = arvalid_i && axi_arready;
  assign r_hs       = rready_i && axi_rvalid;
  assign beat_fault = (axi_rresp != AXI_RESP_OKAY);

  assign inst_valid     = (count != '0);
  assign pop            = io_inst_ready && !io_redirect_valid;
  assign pop_ok         = pop && inst_valid;
  assign push           = (state == ST_R) && r_hs && !io_redirect_valid;
  assign cnt_after_push = count + CNT_W'(1) - CNT_W'(pop_ok);
  assign cnt_after_pop  = count - CNT_W'(pop_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_AR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_AR:
        if (ar_hs) state_next = (drop || io_redirect_valid) ? ST_DRAIN : ST_R;
      ST_R:
        if (io_redirect_valid) begin
          if (r_hs) state_next = ST_AR;
          else      state_next = ST_DRAIN;
        end else if (r_hs) begin
          if (beat_fault)                              state_next = ST_HALT;
          else if (cnt_after_push < CNT_W'(FIFO_DEPTH)) state_next = ST_AR;
          else                                         state_next = ST_WAIT;
        end
      ST_WAIT:
        if (io_redirect_valid || (cnt_after_pop < CNT_W'(FIFO_DEPTH))) state_next = ST_AR;
      ST_DRAIN:
        if (r_hs) state_next = ST_AR;
      ST_HALT:
        if (io_redirect_valid) state_next = ST_AR;
      default:
        state_next = ST_AR;
    endcase
  end

  always_comb begin
    arvalid_i = 1'b0;
    rready_i  = 1'b0;
    case (state)
      ST_AR:             arvalid_i = run;
      ST_R, ST_DRAIN:    rready_i  = run;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      held_pc  <= RESET_PC;
      drop     <= 1'b0;
      cap_pc   <= '0;
      cap_lane <= '0;
    end else begin
      run <= 1'b1;
      if (ar_hs) begin
        cap_pc   <= araddr_i;
        cap_lane <= lane_at_ar;
      end
      if (io_redirect_valid) fetch_pc <= io_redirect_pc & ALIGN_MASK;
      else if (push)         fetch_pc <= fetch_pc + PC_STEP;
      if (arvalid_i && io_redirect_valid && !axi_arready && !drop) begin
        drop    <= 1'b1;
        held_pc <= fetch_pc;
      end else if ((state == ST_DRAIN) && r_hs) begin
        drop <= 1'b0;
      end
    end
  end

  always_comb begin
    lane_inst = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (cap_lane == LANE_W'(i)) lane_inst = axi_rdata[i*INST_W +: INST_W];
    end
  end

  assign push_entry = '{fault: beat_fault, pc: cap_pc, inst: lane_inst};

  ifu_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign io_inst_valid = inst_valid;
  assign io_inst       = inst_valid ? head.inst  : '0;
  assign io_inst_pc    = inst_valid ? head.pc    : '0;
  assign io_inst_fault = inst_valid ? head.fault : 1'b0;
  assign axi_arvalid   = arvalid_i;
  assign axi_araddr    = arvalid_i ? araddr_i : '0;
  assign axi_rready    = rready_i;

endmodule

// File: tb/tb_ifu_axi_prefetch.sv
// Directed bench for ifu_axi_prefetch: sequential fetch, backpressure, redirects, fault, reset.
module tb_ifu_axi_prefetch;

  logic        clock;
  logic        reset;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic [31:0] io_inst;
  logic [31:0] io_inst_pc;
  logic        io_inst_fault;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  int total = 0;
  int bad   = 0;

  ifu_axi_prefetch #(
    .ADDR_W     (32),
    .DATA_W     (64),
    .INST_W     (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc),
    .io_inst_valid     (io_inst_valid),
    .io_inst_ready     (io_inst_ready),
    .io_inst           (io_inst),
    .io_inst_pc        (io_inst_pc),
    .io_inst_fault     (io_inst_fault),
    .axi_araddr        (axi_araddr),
    .axi_arvalid       (axi_arvalid),
    .axi_arready       (axi_arready),
    .axi_rdata         (axi_rdata),
    .axi_rresp         (axi_rresp),
    .axi_rvalid        (axi_rvalid),
    .axi_rready        (axi_rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for arvalid, checks the address, then handshakes for one cycle.
  task automatic ar_phase(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!axi_arvalid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_arvalid"}, 64'(axi_arvalid), 64'd1);
    chk({tag, "_araddr"}, 64'(axi_araddr), 64'(exp_addr));
    axi_arready = 1'b1;
    @(negedge clock);
    axi_arready = 1'b0;
  endtask

  // Memory word at 8-byte aligned address A reads back as {A+4, A}.
  task automatic r_phase(input int lat, input logic [31:0] addr, input logic [1:0] resp);
    logic [31:0] base;
    base = {addr[31:3], 3'b000};
    repeat (lat) @(negedge clock);
    axi_rvalid = 1'b1;
    axi_rresp  = resp;
    axi_rdata  = {base + 32'd4, base};
    @(negedge clock);
    axi_rvalid = 1'b0;
    axi_rresp  = 2'b00;
    axi_rdata  = '0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [1:0] resp);
    ar_phase(tag, addr);
    r_phase(0, addr, resp);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic fault);
    chk({tag, "_valid"}, 64'(io_inst_valid), 64'd1);
    chk({tag, "_pc"},    64'(io_inst_pc),    64'(pc));
    chk({tag, "_inst"},  64'(io_inst),       64'(pc));
    chk({tag, "_fault"}, 64'(io_inst_fault), 64'(fault));
  endtask

  initial begin
    reset             = 1'b0;
    io_redirect_valid = 1'b0;
    io_redirect_pc    = '0;
    io_inst_ready     = 1'b0;
    axi_arready       = 1'b0;
    axi_rdata         = '0;
    axi_rresp         = 2'b00;
    axi_rvalid        = 1'b0;

    #2;
    chk("rst_arvalid", 64'(axi_arvalid),   64'd0);
    chk("rst_rready",  64'(axi_rready),    64'd0);
    chk("rst_ivalid",  64'(io_inst_valid), 64'd0);
    chk("rst_araddr",  64'(axi_araddr),    64'd0);
    repeat (2) @(negedge clock);
    reset         = 1'b1;
    io_inst_ready = 1'b1;

    // Sequential fetch, consumer always ready; lane alternates per word.
    fetch("t1_a", 32'h8000_0000, 2'b00);
    check_head("t1_a", 32'h8000_0000, 1'b0);
    fetch("t1_b", 32'h8000_0004, 2'b00);
    check_head("t1_b", 32'h8000_0004, 1'b0);
    fetch("t1_c", 32'h8000_0008, 2'b00);
    check_head("t1_c", 32'h8000_0008, 1'b0);
    @(negedge clock);
    io_inst_ready = 1'b0;
    chk("t2_empty", 64'(io_inst_valid), 64'd0);

    // Backpressure: four entries fill the FIFO, then no new request until a pop.
    fetch("t2_a", 32'h8000_000C, 2'b00);
    fetch("t2_b", 32'h8000_0010, 2'b00);
    fetch("t2_c", 32'h8000_0014, 2'b00);
    fetch("t2_d", 32'h8000_0018, 2'b00);
    check_head("t2_full", 32'h8000_000C, 1'b0);
    chk("t2_wait0", 64'(axi_arvalid), 64'd0);
    repeat (3) begin
      @(negedge clock);
      chk("t2_wait", 64'(axi_arvalid), 64'd0);
    end
    io_inst_ready = 1'b1;
    @(negedge clock);
    io_inst_ready = 1'b0;
    chk("t2_resume_arvalid", 64'(axi_arvalid), 64'd1);
    chk("t2_resume_araddr",  64'(axi_araddr),  64'h8000_001C);
    chk("t2_head_after_pop", 64'(io_inst_pc),  64'h8000_0010);

    // Redirect while waiting for rvalid: beat dropped, FIFO flushed.
    ar_phase("t3", 32'h8000_001C);
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h8000_0100;
    @(negedge clock);
    io_redirect_valid = 1'b0;
    chk("t3_flushed", 64'(io_inst_valid), 64'd0);
    chk("t3_drain_rready", 64'(axi_rready), 64'd1);
    chk("t3_no_ar", 64'(axi_arvalid), 64'd0);
    @(negedge clock);
    r_phase(0, 32'h8000_001C, 2'b00);
    chk("t3_dropped", 64'(io_inst_valid), 64'd0);
    chk("t3_arvalid", 64'(axi_arvalid),   64'd1);
    chk("t3_araddr",  64'(axi_araddr),    64'h8000_0100);

    // Redirect in AR with arready low: old address held, its beat dropped.
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h8000_0200;
    @(negedge clock);
    io_redirect_valid = 1'b0;
    repeat (2) begin
      chk("t4_hold_addr",    64'(axi_araddr),  64'h8000_0100);
      chk("t4_hold_arvalid", 64'(axi_arvalid), 64'd1);
      @(negedge clock);
    end
    ar_phase("t4_old", 32'h8000_0100);
    chk("t4_drain_rready", 64'(axi_rready), 64'd1);
    r_phase(0, 32'h8000_0100, 2'b00);
    chk("t4_dropped", 64'(io_inst_valid), 64'd0);
    chk("t4_arvalid", 64'(axi_arvalid),   64'd1);
    chk("t4_araddr",  64'(axi_araddr),    64'h8000_0200);
    fetch("t4_new", 32'h8000_0200, 2'b00);
    check_head("t4_new", 32'h8000_0200, 1'b0);

    // Reset asserted mid-read clears outputs without a clock edge.
    ar_phase("t5", 32'h8000_0204);
    chk("t5_pre_rready", 64'(axi_rready), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_arvalid", 64'(axi_arvalid),   64'd0);
    chk("t5_rready",  64'(axi_rready),    64'd0);
    chk("t5_ivalid",  64'(io_inst_valid), 64'd0);
    repeat (2) @(negedge clock);
    reset         = 1'b1;
    io_inst_ready = 1'b1;

    // Error response: faulting entry delivered, then fetch halts until redirect.
    fetch("t6_a", 32'h8000_0000, 2'b00);
    check_head("t6_a", 32'h8000_0000, 1'b0);
    fetch("t6_b", 32'h8000_0004, 2'b00);
    check_head("t6_b", 32'h8000_0004, 1'b0);
    fetch("t6_f", 32'h8000_0008, 2'b10);
    check_head("t6_f", 32'h8000_0008, 1'b1);
    repeat (4) begin
      @(negedge clock);
      chk("t6_halt", 64'(axi_arvalid), 64'd0);
    end
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h8000_004F;
    @(negedge clock);
    io_redirect_valid = 1'b0;
    chk("t6_redir_arvalid", 64'(axi_arvalid), 64'd1);
    fetch("t6_redir", 32'h8000_004C, 2'b00);
    check_head("t6_redir", 32'h8000_004C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
